// File: rtl/addsub_wide_pipe.sv
// Wide add/subtract with the carry registered between SLICE_W-bit slices; one op per
// enabled cycle, latency NSLICE+1 enabled edges. ADDSUB_FLAGS_EN adds ZERO_OUT/NEG_OUT.
module addsub_wide_pipe #(
  parameter int DATA_W  = 95,
  parameter int SLICE_W = 48
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] AIN,
  input  logic [DATA_W-1:0] BIN,
  input  logic              ADD_SUB,
  output logic              OUT_VALID,
  output logic [DATA_W:0]   SUM_OUT
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic              ZERO_OUT,
  output logic              NEG_OUT
`endif
);

  localparam int RES_W  = DATA_W + 1;
  localparam int NSLICE = (RES_W + SLICE_W - 1) / SLICE_W;

  logic [RES_W-1:0]  a_ext;
  logic [RES_W-1:0]  b_ext;
  logic [NSLICE-1:0] carry;
  logic [NSLICE:0]   vld_sr;
  logic [RES_W-1:0]  res_full;

  // Subtract is A + ~B + 1: B is inverted up front and the +1 enters as slice 0 carry-in.
  assign a_ext    = {1'b0, AIN};
  assign b_ext    = ADD_SUB ? ~{1'b0, BIN} : {1'b0, BIN};
  assign carry[0] = ADD_SUB;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    localparam int LO  = s * SLICE_W;
    localparam int OPW = RES_W - LO;
    localparam int SW  = (s == NSLICE - 1) ? OPW : SLICE_W;

    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic             cin_q;
    logic [OPW-1:0]   a_src;
    logic [OPW-1:0]   b_src;
    logic [SW-1:0]    slice_res;
    logic [LO+SW-1:0] res_nxt;
    logic [LO+SW-1:0] res_q;

    if (s == 0) begin : g_first
      assign a_src   = a_ext;
      assign b_src   = b_ext;
      assign res_nxt = slice_res;
    end else begin : g_next
      // Operand bits below this slice were consumed upstream; only the skewed upper part travels on.
      assign a_src   = g_slice[s-1].a_q[OPW+SLICE_W-1:SLICE_W];
      assign b_src   = g_slice[s-1].b_q[OPW+SLICE_W-1:SLICE_W];
      assign res_nxt = {slice_res, g_slice[s-1].res_q};
    end

    if (s < NSLICE - 1) begin : g_mid
      logic [SW:0] sum;
      assign sum          = {1'b0, a_q[SW-1:0]} + {1'b0, b_q[SW-1:0]} + (SW+1)'(cin_q);
      assign slice_res    = sum[SW-1:0];
      assign carry[s + 1] = sum[SW];
    end else begin : g_top
      assign slice_res = a_q[SW-1:0] + b_q[SW-1:0] + SW'(cin_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        a_q   <= '0;
        b_q   <= '0;
        cin_q <= 1'b0;
        res_q <= '0;
      end else if (CE) begin
        a_q   <= a_src;
        b_q   <= b_src;
        cin_q <= carry[s];
        res_q <= res_nxt;
      end
    end
  end

  assign res_full = g_slice[NSLICE-1].res_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_sr    <= '0;
      OUT_VALID <= 1'b0;
      SUM_OUT   <= '0;
    end else if (CE) begin
      vld_sr    <= {vld_sr[NSLICE-1:0], IN_VALID};
      OUT_VALID <= vld_sr[NSLICE];
      if (vld_sr[NSLICE]) begin
        SUM_OUT <= res_full;
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic [NSLICE:0] mode_sr;

  // With zero-extended operands the result MSB is set exactly when a subtract borrows.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_sr  <= '0;
      ZERO_OUT <= 1'b0;
      NEG_OUT  <= 1'b0;
    end else if (CE) begin
      mode_sr <= {mode_sr[NSLICE-1:0], ADD_SUB};
      if (vld_sr[NSLICE]) begin
        ZERO_OUT <= (res_full == '0);
        NEG_OUT  <= mode_sr[NSLICE] & res_full[DATA_W];
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_wide_pipe.sv
// Bench for addsub_wide_pipe: default build (95/48) and a 20/8 build driven side by side.
module tb_addsub_wide_pipe;
  localparam int LAT0 = 3;  // ceil(96/48)+1
  localparam int LAT1 = 4;  // ceil(21/8)+1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        add_sub = 1'b0;
  logic [94:0] a0 = '0, b0 = '0;
  logic [19:0] a1 = '0, b1 = '0;
  logic        ov0, ov1;
  logic [95:0] s0;
  logic [20:0] s1;
`ifdef ADDSUB_FLAGS_EN
  logic        z0, n0, z1, n1;
`endif

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  addsub_wide_pipe #(.DATA_W(95), .SLICE_W(48)) dut0 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid), .AIN(a0), .BIN(b0),
    .ADD_SUB(add_sub), .OUT_VALID(ov0), .SUM_OUT(s0)
`ifdef ADDSUB_FLAGS_EN
    , .ZERO_OUT(z0), .NEG_OUT(n0)
`endif
  );

  addsub_wide_pipe #(.DATA_W(20), .SLICE_W(8)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid), .AIN(a1), .BIN(b1),
    .ADD_SUB(add_sub), .OUT_VALID(ov1), .SUM_OUT(s1)
`ifdef ADDSUB_FLAGS_EN
    , .ZERO_OUT(z1), .NEG_OUT(n1)
`endif
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] ref_res(input int d, input logic [94:0] a,
                                          input logic [94:0] b, input logic m);
    logic [95:0] r;
    r = m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    if (d == 1) r[95:21] = '0;
    return r;
  endfunction

  // Model: history of inputs per enabled edge; output at edge n reflects the op sampled at n-LAT.
  logic [94:0] ha [2][64];
  logic [94:0] hb [2][64];
  logic        hm [64];
  logic        hv [64];
  logic        ev [2];
  logic [95:0] es [2];
  logic        ez [2];
  logic        en [2];
  int          ecnt = 0;
  int          k, j, lat;
  logic        ce_edge;

  always @(posedge clk) begin
    ce_edge = ce && rst_n;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) hv[i] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        ev[d] = 1'b0; es[d] = '0; ez[d] = 1'b0; en[d] = 1'b0;
      end
      ecnt = 0;
    end else if (ce) begin
      k = ecnt % 64;
      ha[0][k] = a0;
      hb[0][k] = b0;
      ha[1][k] = {75'b0, a1};
      hb[1][k] = {75'b0, b1};
      hm[k] = add_sub;
      hv[k] = in_valid;
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? LAT0 : LAT1;
        ev[d] = 1'b0;
        if (ecnt >= lat) begin
          j = (ecnt - lat) % 64;
          ev[d] = hv[j];
          if (hv[j]) begin
            es[d] = ref_res(d, ha[d][j], hb[d][j], hm[j]);
            ez[d] = (es[d] == '0);
            en[d] = hm[j] && (ha[d][j] < hb[d][j]);
          end
        end
      end
      ecnt++;
    end
    #1;
    chk("ov0", {95'b0, ov0}, {95'b0, ev[0]});
    chk("sum0", s0, es[0]);
    chk("ov1", {95'b0, ov1}, {95'b0, ev[1]});
    chk("sum1", {75'b0, s1}, es[1]);
`ifdef ADDSUB_FLAGS_EN
    chk("zero0", {95'b0, z0}, {95'b0, ez[0]});
    chk("neg0", {95'b0, n0}, {95'b0, en[0]});
    chk("zero1", {95'b0, z1}, {95'b0, ez[1]});
    chk("neg1", {95'b0, n1}, {95'b0, en[1]});
`endif
    if (ce_edge && ov0) ov_cnt++;
  end

  task automatic drive(input logic [94:0] a, input logic [94:0] b, input logic m, input logic v);
    a0 = a;
    b0 = b;
    a1 = a[19:0];
    b1 = b[19:0];
    add_sub = m;
    in_valid = v;
  endtask

  task automatic directed(input string nm, input logic [94:0] a, input logic [94:0] b,
                          input logic m, input logic [95:0] exp, input logic exp_neg);
    @(negedge clk);
    drive(a, b, m, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    repeat (LAT0) @(negedge clk);
    chk({nm, "_vld"}, {95'b0, ov0}, 96'd1);
    chk({nm, "_sum"}, s0, exp);
`ifdef ADDSUB_FLAGS_EN
    chk({nm, "_neg"}, {95'b0, n0}, {95'b0, exp_neg});
    chk({nm, "_zero"}, {95'b0, z0}, {95'b0, (exp == '0)});
`else
    if (exp_neg === 1'bx) $display("unexpected X flag for %s", nm);
`endif
    @(negedge clk);
    chk({nm, "_pulse"}, {95'b0, ov0}, 96'd0);
    chk({nm, "_hold"}, s0, exp);
  endtask

  function automatic logic [94:0] rnd95();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[94:0];
  endfunction

  initial begin
    logic [94:0] ra, rb, ones;
    int sel;
    ones = '1;
    ce = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", {95'b0, ov0}, 96'd0);
    chk("rst_sum", s0, 96'd0);
    rst_n = 1'b1;

    directed("t1_add", 95'd10, 95'd281474976710665, 1'b0, 96'h000000000001000000000013, 1'b0);
    directed("t2_sub", 95'd10, 95'd281474976710665, 1'b1, 96'hFFFFFFFFFFFF000000000001, 1'b1);
    directed("t3_carry", 95'hFFFF_FFFF_FFFF, 95'd1, 1'b0, 96'h000000000001000000000000, 1'b0);
    directed("t3_max", ones, ones, 1'b0, 96'hFFFFFFFFFFFFFFFFFFFFFFFE, 1'b0);

    // Streaming with a two-cycle clock-enable freeze in the middle.
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        ce = 1'b0;
        drive(rnd95(), rnd95(), 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        ce = 1'b1;
      end
      drive(rnd95(), rnd95(), i[0], 1'b1);
    end
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    repeat (LAT0 + 3) @(negedge clk);
    chk("stream_cnt", 96'(ov_cnt), 96'd8);

    // Reset with two ops in flight.
    @(negedge clk);
    drive(95'd100, 95'd7, 1'b0, 1'b1);
    @(negedge clk);
    drive(95'd3, 95'd9, 1'b1, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", {95'b0, ov0}, 96'd0);
    chk("rst_mid_sum", s0, 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    repeat (8) @(negedge clk);
    chk("rst_no_vld", 96'(ov_cnt), 96'd0);
    directed("t5_zero", 95'd5, 95'd5, 1'b1, 96'd0, 1'b0);

    // Randomized traffic with extreme operands mixed in.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ce = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 7);
      ra = (sel == 0) ? ones : (sel == 1) ? '0 : rnd95();
      sel = $urandom_range(0, 7);
      rb = (sel == 0) ? ones : (sel == 1) ? '0 : (sel == 2) ? ra : rnd95();
      drive(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    ce = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (LAT1 + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
